tour_cmd: RTL



---
 rtl/tour_pkg.sv | 25 ++
 rtl/tour_cmd_move_decode.sv | 29 ++
 rtl/tour_cmd.sv | 112 +++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command replay block.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLD_V,
    HORZ,
    HOLD_H
  } state_t;

  localparam int unsigned NUM_MOVES = 24;

  localparam logic [3:0] MOVE_OP    = 4'h2;
  localparam logic [3:0] FANFARE_OP = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

endpackage

// File: rtl/tour_cmd_move_decode.sv
// Combinational split of a one-hot knight move into a vertical move command
// and a horizontal fanfare command; non-one-hot input yields zero-square commands.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        valid
);

  always_comb begin
    valid    = 1'b1;
    vert_cmd = {MOVE_OP, HDG_N, 4'd0};
    horz_cmd = {FANFARE_OP, HDG_N, 4'd0};
    unique case (move)
      8'h01: begin vert_cmd = {MOVE_OP, HDG_N, 4'd2}; horz_cmd = {FANFARE_OP, HDG_E, 4'd1}; end
      8'h02: begin vert_cmd = {MOVE_OP, HDG_N, 4'd2}; horz_cmd = {FANFARE_OP, HDG_W, 4'd1}; end
      8'h04: begin vert_cmd = {MOVE_OP, HDG_N, 4'd1}; horz_cmd = {FANFARE_OP, HDG_W, 4'd2}; end
      8'h08: begin vert_cmd = {MOVE_OP, HDG_S, 4'd1}; horz_cmd = {FANFARE_OP, HDG_W, 4'd2}; end
      8'h10: begin vert_cmd = {MOVE_OP, HDG_S, 4'd2}; horz_cmd = {FANFARE_OP, HDG_W, 4'd1}; end
      8'h20: begin vert_cmd = {MOVE_OP, HDG_S, 4'd2}; horz_cmd = {FANFARE_OP, HDG_E, 4'd1}; end
      8'h40: begin vert_cmd = {MOVE_OP, HDG_S, 4'd1}; horz_cmd = {FANFARE_OP, HDG_E, 4'd2}; end
      8'h80: begin vert_cmd = {MOVE_OP, HDG_N, 4'd1}; horz_cmd = {FANFARE_OP, HDG_E, 4'd2}; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight tour as vertical/horizontal commands to cmd_proc,
// passing UART commands through when idle. Optional bad_move flag: TOUR_CMD_ERR_EN.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES_P = NUM_MOVES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
`ifdef TOUR_CMD_ERR_EN
  ,
  output logic        bad_move
`endif
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES_P - 1);

  state_t      state, state_nxt;
  logic [4:0]  mv_indx_nxt;
  logic [15:0] vert_cmd, horz_cmd;
  logic        move_valid;
  logic        last_move;

  move_decode u_move_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .valid    (move_valid)
  );

  assign last_move = (mv_indx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  // clr_cmd_rdy takes priority in VERT/HORZ; a coincident send_resp is dropped.
  always_comb begin
    state_nxt        = state;
    mv_indx_nxt      = mv_indx;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    unique case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
        if (start_tour) begin
          mv_indx_nxt = '0;
          state_nxt   = VERT;
        end
      end
      VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HOLD_V;
      end
      HOLD_V: begin
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HOLD_H;
      end
      HOLD_H: begin
        cmd = horz_cmd;
        if (last_move) resp = RESP_ACK;
        if (send_resp) begin
          if (last_move) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + 5'd1;
            state_nxt   = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TOUR_CMD_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bad_move <= 1'b0;
    else if (state == IDLE && start_tour)
      bad_move <= 1'b0;
    else if (state == VERT && !move_valid)
      bad_move <= 1'b1;
  end
`endif

endmodule
